// File: rtl/alu_pkg.sv
// Shared ALU/divider constants: divider FSM states, default datapath width
// and the ALUControl encodings for the divide opcodes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_e;

    localparam int DIV_W = 32;

    localparam logic [3:0] DIV  = 4'b0100;
    localparam logic [3:0] SDIV = 4'b0101;

endpackage

// File: rtl/iter_div_if.sv
// Request/response bundle between the execute-stage controller (master)
// and the iterative divider (slave).
interface iter_div_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate; serves both as the
// operand abs() and as the result sign correction.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? ('0 - value) : value;
    end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider for DIV/SDIV (IDLE -> RUN -> FIN).
// Optional macro ITER_DIV_EARLY_OUT_EN skips the iterations when |divisor| > |dividend|.
module iter_div
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       reset,
    iter_div_if.slave bus
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] bmag_q;
    logic [WIDTH-1:0] raw_a;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   diff;
    logic             a_neg;
    logic             b_neg;

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.value(bus.dividend), .negate(a_neg), .result(a_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.value(bus.divisor),  .negate(b_neg), .result(b_mag));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.value(quo_q),        .negate(neg_q), .result(q_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.value(rem_q),        .negate(neg_r), .result(r_fix));

    // Trial subtraction on the shifted partial remainder; diff[WIDTH] set means restore.
    always_comb begin
        diff = {rem_q, quo_q[WIDTH-1]} - {1'b0, bmag_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            bmag_q          <= '0;
            raw_a           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz_q            <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy        <= 1'b1;
                        bus.div_by_zero <= 1'b0;
                        raw_a           <= bus.dividend;
                        bmag_q          <= b_mag;
                        neg_q           <= a_neg ^ b_neg;
                        neg_r           <= a_neg;
                        rem_q           <= '0;
                        quo_q           <= a_mag;
                        dz_q            <= 1'b0;
                        if (bus.divisor == '0) begin
                            dz_q  <= 1'b1;
                            state <= FIN;
                        end
`ifdef ITER_DIV_EARLY_OUT_EN
                        // Remainder goes through the normal sign fix, reproducing the raw dividend.
                        else if (b_mag > a_mag) begin
                            quo_q <= '0;
                            rem_q <= a_mag;
                            state <= FIN;
                        end
`endif
                        else begin
                            cnt   <= CNT_W'(WIDTH);
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    rem_q <= diff[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff[WIDTH-1:0];
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                    if (dz_q) begin
                        bus.quotient    <= '0;
                        bus.remainder   <= raw_a;
                        bus.div_by_zero <= 1'b1;
                    end else begin
                        bus.quotient    <= q_fix;
                        bus.remainder   <= r_fix;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
